// File: rtl/branch_unit.sv
// Branch resolution unit: latches compare flags, owns the program counter and
// redirects it on conditional branches, stalling while a branch waits for flags.
module branch_unit #(
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sign_flag,
  input  logic              zero_flag,
  input  logic              flag_valid,
  input  logic              pc_en,
  input  logic              br_req,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc,
  output logic [1:0]        flags_q,
  output logic              br_taken,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    REDIRECT   = 2'd2
  } state_t;

  localparam logic [2:0] C_ALWAYS = 3'b000;
  localparam logic [2:0] C_NEVER  = 3'b111;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_d;
  logic [1:0]          flags_d;
  logic                fresh_q, fresh_d;
  logic                taken_q, taken_d;
  logic [ADDR_W-1:0]   target_q, target_d;
  logic [2:0]          cond_q, cond_d;
  logic [ADDR_W-1:0]   pc_inc;
  logic                flags_avail;
  logic                src_zero, src_sign;

  function automatic logic eval_cond(input logic [2:0] c, input logic z, input logic s);
    case (c)
      3'b000:  eval_cond = 1'b1;
      3'b001:  eval_cond = s;
      3'b010:  eval_cond = ~s;
      3'b011:  eval_cond = z;
      3'b100:  eval_cond = ~z;
      3'b101:  eval_cond = s | z;
      3'b110:  eval_cond = ~s & ~z;
      default: eval_cond = 1'b0;
    endcase
  endfunction

  // Modulo-2^ADDR_W wrap falls out of the truncating add.
  assign pc_inc = pc + ADDR_W'(PC_STEP);

  // Same-cycle flags bypass the status register.
  assign flags_avail = flag_valid | fresh_q;
  assign src_zero    = flag_valid ? zero_flag : flags_q[1];
  assign src_sign    = flag_valid ? sign_flag : flags_q[0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d  = state_q;
    pc_d     = pc;
    flags_d  = flags_q;
    fresh_d  = fresh_q;
    taken_d  = taken_q;
    target_d = target_q;
    cond_d   = cond_q;

    if (flag_valid) begin
      flags_d = {zero_flag, sign_flag};
      fresh_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (br_req) begin
          target_d = br_target;
          if (br_cond == C_ALWAYS || br_cond == C_NEVER) begin
            taken_d = (br_cond == C_ALWAYS);
            state_d = REDIRECT;
          end else if (flags_avail) begin
            taken_d = eval_cond(br_cond, src_zero, src_sign);
            fresh_d = 1'b0;
            state_d = REDIRECT;
          end else begin
            cond_d  = br_cond;
            state_d = WAIT_FLAGS;
          end
        end else if (pc_en) begin
          pc_d = pc_inc;
        end
      end
      WAIT_FLAGS: begin
        if (flag_valid) begin
          taken_d = eval_cond(cond_q, zero_flag, sign_flag);
          fresh_d = 1'b0;
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        pc_d    = taken_q ? target_q : pc_inc;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc       <= RESET_PC;
      flags_q  <= 2'b00;
      fresh_q  <= 1'b0;
      taken_q  <= 1'b0;
      target_q <= '0;
      cond_q   <= 3'b000;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      pc       <= pc_d;
      flags_q  <= flags_d;
      fresh_q  <= fresh_d;
      taken_q  <= taken_d;
      target_q <= target_d;
      cond_q   <= cond_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign br_taken = (state_q == REDIRECT) & taken_q;

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: directed vector table, hand sequences for wrap and
// reset abort, then random stimulus against a behavioural reference model.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sign_flag, zero_flag, flag_valid, pc_en, br_req;
  logic [2:0]  br_cond;
  logic [19:0] br_target;
  logic [19:0] pc;
  logic [1:0]  flags_q;
  logic        br_taken, busy;

  int n_checks = 0;
  int n_fail   = 0;

  branch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .sign_flag(sign_flag), .zero_flag(zero_flag), .flag_valid(flag_valid),
    .pc_en(pc_en), .br_req(br_req), .br_cond(br_cond), .br_target(br_target),
    .pc(pc), .flags_q(flags_q), .br_taken(br_taken), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: architectural state plus the pending-branch bookkeeping.
  logic [19:0] m_pc;
  logic [1:0]  m_flags;
  bit          m_fresh, m_waiting, m_redirect, m_taken;
  logic [19:0] m_target;
  int          m_cond;

  function automatic bit cond_true(int c, bit z, bit s);
    case (c)
      0: return 1;
      1: return s;
      2: return !s;
      3: return z;
      4: return !z;
      5: return s || z;
      6: return !s && !z;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 20'h00000; m_flags = 2'b00; m_fresh = 0;
    m_waiting = 0; m_redirect = 0; m_taken = 0; m_target = '0; m_cond = 0;
  endtask

  task automatic model_step();
    bit consumed;
    consumed = 0;
    if (m_redirect) begin
      m_pc = m_taken ? m_target : 20'((int'(m_pc) + 1) % (1 << 20));
      m_redirect = 0;
    end else if (m_waiting) begin
      if (flag_valid) begin
        m_taken = cond_true(m_cond, zero_flag, sign_flag);
        consumed = 1; m_waiting = 0; m_redirect = 1;
      end
    end else if (br_req) begin
      m_target = br_target;
      if (br_cond == 0 || br_cond == 7) begin
        m_taken = (br_cond == 0); m_redirect = 1;
      end else if (flag_valid) begin
        m_taken = cond_true(br_cond, zero_flag, sign_flag);
        consumed = 1; m_redirect = 1;
      end else if (m_fresh) begin
        m_taken = cond_true(br_cond, m_flags[1], m_flags[0]);
        consumed = 1; m_redirect = 1;
      end else begin
        m_cond = br_cond; m_waiting = 1;
      end
    end else if (pc_en) begin
      m_pc = 20'((int'(m_pc) + 1) % (1 << 20));
    end
    if (flag_valid) begin
      m_flags = {zero_flag, sign_flag};
      m_fresh = 1;
    end
    if (consumed) m_fresh = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input bit fv, input bit z, input bit s, input bit pe, input bit br,
                      input logic [2:0] c, input logic [19:0] t);
    flag_valid = fv; zero_flag = z; sign_flag = s; pc_en = pe; br_req = br;
    br_cond = c; br_target = t;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 3'd0, 20'h0);
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_pc"},    32'(pc),       32'(m_pc));
    check({tag, "_flags"}, 32'(flags_q),  32'(m_flags));
    check({tag, "_busy"},  32'(busy),     32'(m_waiting || m_redirect));
    check({tag, "_taken"}, 32'(br_taken), 32'(m_redirect && m_taken));
  endtask

  typedef struct packed {
    logic        fv, z, s, pe, br;
    logic [2:0]  cond;
    logic [19:0] target;
    logic [19:0] e_pc;
    logic        e_busy, e_taken;
    logic [1:0]  e_flags;
  } vec_t;

  function automatic vec_t mk(bit fv, bit z, bit s, bit pe, bit br, logic [2:0] c,
                              logic [19:0] t, logic [19:0] epc, bit eb, bit et,
                              logic [1:0] ef);
    vec_t v;
    v.fv = fv; v.z = z; v.s = s; v.pe = pe; v.br = br; v.cond = c; v.target = t;
    v.e_pc = epc; v.e_busy = eb; v.e_taken = et; v.e_flags = ef;
    return v;
  endfunction

  vec_t vecs[21];

  initial begin
    // Starts at pc=00010, fresh clear, flags 00.
    vecs[0]  = mk(1,0,1, 0,1, 3'd1, 20'hABCDE, 20'h00010, 1,1, 2'b01); // LT bypass
    vecs[1]  = mk(0,0,0, 0,0, 3'd0, 20'h0,     20'hABCDE, 0,0, 2'b01);
    vecs[2]  = mk(1,0,1, 0,0, 3'd0, 20'h0,     20'hABCDE, 0,0, 2'b01); // fresh
    vecs[3]  = mk(0,0,0, 0,1, 3'd2, 20'h54321, 20'hABCDE, 1,0, 2'b01); // GE not taken
    vecs[4]  = mk(0,0,0, 0,0, 3'd0, 20'h0,     20'hABCDF, 0,0, 2'b01);
    vecs[5]  = mk(0,0,0, 1,1, 3'd3, 20'h00777, 20'hABCDF, 1,0, 2'b01); // stall
    vecs[6]  = mk(0,0,0, 1,1, 3'd0, 20'h12345, 20'hABCDF, 1,0, 2'b01);
    vecs[7]  = mk(0,0,0, 1,0, 3'd0, 20'h0,     20'hABCDF, 1,0, 2'b01);
    vecs[8]  = mk(0,0,0, 1,0, 3'd0, 20'h0,     20'hABCDF, 1,0, 2'b01);
    vecs[9]  = mk(1,1,0, 0,0, 3'd0, 20'h0,     20'hABCDF, 1,1, 2'b10);
    vecs[10] = mk(0,0,0, 0,0, 3'd0, 20'h0,     20'h00777, 0,0, 2'b10);
    vecs[11] = mk(1,0,1, 0,0, 3'd0, 20'h0,     20'h00777, 0,0, 2'b01); // fresh
    vecs[12] = mk(0,0,0, 0,1, 3'd7, 20'h11111, 20'h00777, 1,0, 2'b01); // NEVER
    vecs[13] = mk(0,0,0, 0,0, 3'd0, 20'h0,     20'h00778, 0,0, 2'b01);
    vecs[14] = mk(0,0,0, 0,1, 3'd0, 20'h22222, 20'h00778, 1,1, 2'b01); // ALWAYS
    vecs[15] = mk(0,0,0, 0,0, 3'd0, 20'h0,     20'h22222, 0,0, 2'b01);
    vecs[16] = mk(0,0,0, 0,1, 3'd1, 20'h33333, 20'h22222, 1,1, 2'b01); // LT, latched
    vecs[17] = mk(0,0,0, 0,0, 3'd0, 20'h0,     20'h33333, 0,0, 2'b01);
    vecs[18] = mk(0,0,0, 0,1, 3'd1, 20'h44444, 20'h33333, 1,0, 2'b01); // now stalls
    vecs[19] = mk(1,0,0, 0,0, 3'd0, 20'h0,     20'h33333, 1,0, 2'b00);
    vecs[20] = mk(0,0,0, 0,0, 3'd0, 20'h0,     20'h33334, 0,0, 2'b00);

    rst_n = 1'b0;
    flag_valid = 0; zero_flag = 0; sign_flag = 0; pc_en = 0; br_req = 0;
    br_cond = 3'd0; br_target = 20'h0;
    model_reset();
    #12;
    check("reset_pc",    32'(pc),       32'h0);
    check("reset_flags", 32'(flags_q),  32'h0);
    check("reset_busy",  32'(busy),     32'h0);
    check("reset_taken", 32'(br_taken), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 0, 3'd0, 20'h0);
    check("preamble_pc", 32'(pc), 32'h00010);

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].fv, vecs[i].z, vecs[i].s, vecs[i].pe, vecs[i].br,
           vecs[i].cond, vecs[i].target);
      check($sformatf("vec%0d_pc", i),    32'(pc),       32'(vecs[i].e_pc));
      check($sformatf("vec%0d_busy", i),  32'(busy),     32'(vecs[i].e_busy));
      check($sformatf("vec%0d_taken", i), 32'(br_taken), 32'(vecs[i].e_taken));
      check($sformatf("vec%0d_flags", i), 32'(flags_q),  32'(vecs[i].e_flags));
    end

    // PC wrap, then br_req winning over a simultaneous pc_en.
    step(0, 0, 0, 0, 1, 3'd0, 20'hFFFFF);
    idle();
    check("wrap_setup_pc", 32'(pc), 32'hFFFFF);
    step(0, 0, 0, 1, 0, 3'd0, 20'h0);
    check("wrap_pc", 32'(pc), 32'h00000);
    step(0, 0, 0, 1, 1, 3'd0, 20'h00100);
    check("prio_pc_hold", 32'(pc), 32'h00000);
    check("prio_busy", 32'(busy), 32'h1);
    idle();
    check("prio_pc", 32'(pc), 32'h00100);

    // Reset asserted mid-branch while br_taken is high.
    step(1, 1, 1, 0, 0, 3'd0, 20'h0);
    step(0, 0, 0, 0, 1, 3'd0, 20'h00005);
    check("pre_rst_taken", 32'(br_taken), 32'h1);
    check("pre_rst_flags", 32'(flags_q),  32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pc",    32'(pc),       32'h0);
    check("midrst_flags", 32'(flags_q),  32'h0);
    check("midrst_busy",  32'(busy),     32'h0);
    check("midrst_taken", 32'(br_taken), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("post_rst_pc", 32'(pc), 32'h0);
    compare_model("post_rst");

    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 3) == 0, 3'($urandom), 20'($urandom));
      compare_model($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
